ifft8_seq: RTL and testbench

Sequential 8-point radix-2 inverse FFT: the reconstruction path paired with the combinational 8-point forward FFT. It accepts one frame of 8 complex 12-bit bins serially, runs 12 butterflies on one shared multiplier pair, then streams out 8 complex 12-bit time samples. Twiddles use the same ×10 fixed-point scaling as the forward FFT, so the two blocks can be checked against each other round-trip.

---
 rtl/ifft8_seq.sv | 210 +++++++++++++++++++++
 tb/tb_ifft8_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft8_seq.sv
// ifft8_seq: sequential 8-point radix-2 inverse FFT.
// Loads 8 complex bins serially (bit-reversed addressing), runs 12 butterflies
// on one shared complex multiplier, then streams out 8 time samples scaled by 1/8.
module ifft8_seq #(
  parameter int unsigned W  = 12,
  parameter int unsigned IW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic                out_last,
  output logic                busy
);

  // Product width: IW-bit data times 5-bit twiddle, plus one bit for the sum.
  localparam int unsigned PW = IW + 6;
  localparam logic signed [PW-1:0] TW_SCALE = PW'(10);
  localparam logic signed [IW-1:0] SAT_MAX  = IW'((2 ** (W - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN  = IW'(-(2 ** (W - 1)));
  localparam logic [3:0]           BF_LAST  = 4'd11;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  state_t               r_state;
  logic [2:0]           r_in_cnt;
  logic [2:0]           r_out_cnt;
  logic [3:0]           r_bf_cnt;
  logic signed [IW-1:0] r_re [8];
  logic signed [IW-1:0] r_im [8];

  logic                 w_in_fire;
  logic [2:0]           w_ld_addr;
  logic [2:0]           w_next_idx;
  logic [1:0]           w_m;
  logic [2:0]           w_p;
  logic [2:0]           w_q;
  logic [1:0]           w_k;
  logic signed [4:0]    w_wr;
  logic signed [4:0]    w_wi;
  logic signed [IW-1:0] w_ar;
  logic signed [IW-1:0] w_ai;
  logic signed [IW-1:0] w_br;
  logic signed [IW-1:0] w_bi;
  logic signed [PW-1:0] w_pr;
  logic signed [PW-1:0] w_pi;
  logic signed [IW-1:0] w_tr;
  logic signed [IW-1:0] w_ti;
  logic signed [IW-1:0] w_a_re_n;
  logic signed [IW-1:0] w_a_im_n;
  logic signed [IW-1:0] w_b_re_n;
  logic signed [IW-1:0] w_b_im_n;

  // Output scaling: arithmetic shift by 3, then clamp to the W-bit range.
  function automatic logic signed [W-1:0] scale_sat(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] sh;
    sh = v >>> 3;
    if (sh > SAT_MAX) begin
      sh = SAT_MAX;
    end else if (sh < SAT_MIN) begin
      sh = SAT_MIN;
    end
    return sh[W-1:0];
  endfunction

  assign w_in_fire  = in_valid & in_ready;
  assign w_ld_addr  = {r_in_cnt[0], r_in_cnt[1], r_in_cnt[2]};
  assign w_next_idx = r_out_cnt + 3'd1;
  assign w_m        = r_bf_cnt[1:0];

  // Butterfly addressing: insert a zero at bit s of the in-stage index to get p.
  always_comb begin
    w_p = 3'd0;
    w_q = 3'd0;
    w_k = 2'd0;
    case (r_bf_cnt[3:2])
      2'd0: begin
        w_p = {w_m, 1'b0};
        w_q = {w_m, 1'b1};
        w_k = 2'd0;
      end
      2'd1: begin
        w_p = {w_m[1], 1'b0, w_m[0]};
        w_q = {w_m[1], 1'b1, w_m[0]};
        w_k = {w_m[0], 1'b0};
      end
      default: begin
        w_p = {1'b0, w_m};
        w_q = {1'b1, w_m};
        w_k = w_m;
      end
    endcase
  end

  // Inverse twiddle table, scaled by 10.
  always_comb begin
    w_wr = 5'sd10;
    w_wi = 5'sd0;
    case (w_k)
      2'd0: begin w_wr = 5'sd10;  w_wi = 5'sd0;  end
      2'd1: begin w_wr = 5'sd7;   w_wi = 5'sd7;  end
      2'd2: begin w_wr = 5'sd0;   w_wi = 5'sd10; end
      default: begin w_wr = -5'sd7; w_wi = 5'sd7; end
    endcase
  end

  assign w_ar = r_re[w_p];
  assign w_ai = r_im[w_p];
  assign w_br = r_re[w_q];
  assign w_bi = r_im[w_q];

  assign w_pr = PW'(w_br) * PW'(w_wr) - PW'(w_bi) * PW'(w_wi);
  assign w_pi = PW'(w_br) * PW'(w_wi) + PW'(w_bi) * PW'(w_wr);
  assign w_tr = IW'(w_pr / TW_SCALE);
  assign w_ti = IW'(w_pi / TW_SCALE);

  assign w_a_re_n = w_ar + w_tr;
  assign w_a_im_n = w_ai + w_ti;
  assign w_b_re_n = w_ar - w_tr;
  assign w_b_im_n = w_ai - w_ti;

  // Working buffer: bit-reversed load, in-place butterfly writes; no reset needed.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD && w_in_fire) begin
      r_re[w_ld_addr] <= IW'(in_re);
      r_im[w_ld_addr] <= IW'(in_im);
    end else if (r_state == ST_COMPUTE) begin
      r_re[w_p] <= w_a_re_n;
      r_im[w_p] <= w_a_im_n;
      r_re[w_q] <= w_b_re_n;
      r_im[w_q] <= w_b_im_n;
    end
  end

  // Control FSM with registered handshake and output data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_LOAD;
      r_in_cnt  <= 3'd0;
      r_out_cnt <= 3'd0;
      r_bf_cnt  <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_in_cnt <= r_in_cnt + 3'd1;
            if (r_in_cnt == 3'd7) begin
              r_state  <= ST_COMPUTE;
              r_bf_cnt <= 4'd0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          r_bf_cnt <= r_bf_cnt + 4'd1;
          if (r_bf_cnt == BF_LAST) begin
            // buf[0] was finalised by butterfly 9, so it is safe to read here.
            r_state   <= ST_UNLOAD;
            r_out_cnt <= 3'd0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_re    <= scale_sat(r_re[0]);
            out_im    <= scale_sat(r_im[0]);
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (r_out_cnt == 3'd7) begin
              r_state   <= ST_LOAD;
              r_in_cnt  <= 3'd0;
              r_out_cnt <= 3'd0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              out_re    <= '0;
              out_im    <= '0;
            end else begin
              r_out_cnt <= w_next_idx;
              out_re    <= scale_sat(r_re[w_next_idx]);
              out_im    <= scale_sat(r_im[w_next_idx]);
              out_last  <= (w_next_idx == 3'd7);
            end
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifft8_seq.sv
// tb_ifft8_seq: directed and randomized frames for ifft8_seq, checked against
// literal expectations and a behavioural inverse-FFT model.
module tb_ifft8_seq;

  localparam int W  = 12;
  localparam int IW = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic                out_last;
  logic                busy;

  int errors = 0;
  int checks = 0;

  int bin_re [8];
  int bin_im [8];
  int exp_re [8];
  int exp_im [8];
  int tw_re  [4] = '{10, 7, 0, -7};
  int tw_im  [4] = '{0, 7, 10, 7};

  ifft8_seq #(.W(W), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int bitrev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  function automatic int wrap_iw(input int v);
    logic signed [IW-1:0] t;
    t = v[IW-1:0];
    return int'(t);
  endfunction

  // Reference: textbook DIT inverse FFT with integer twiddles and truncating division.
  task automatic model_frame();
    int r [8];
    int m [8];
    int span, q, k, tr, ti, ar, ai, v;
    for (int n = 0; n < 8; n++) begin
      r[bitrev3(n)] = bin_re[n];
      m[bitrev3(n)] = bin_im[n];
    end
    for (int s = 0; s < 3; s++) begin
      span = 1 << s;
      for (int p = 0; p < 8; p++) begin
        if (((p >> s) & 1) == 0) begin
          q  = p + span;
          k  = (p % span) * (4 >> s);
          tr = (r[q] * tw_re[k] - m[q] * tw_im[k]) / 10;
          ti = (r[q] * tw_im[k] + m[q] * tw_re[k]) / 10;
          ar = r[p];
          ai = m[p];
          r[p] = wrap_iw(ar + tr);
          m[p] = wrap_iw(ai + ti);
          r[q] = wrap_iw(ar - tr);
          m[q] = wrap_iw(ai - ti);
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      v = r[n] >>> 3;
      exp_re[n] = (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
      v = m[n] >>> 3;
      exp_im[n] = (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
    end
  endtask

  task automatic set_impulse(input int k, input int re);
    for (int n = 0; n < 8; n++) begin
      bin_re[n] = 0;
      bin_im[n] = 0;
    end
    bin_re[k] = re;
  endtask

  task automatic drive_frame(input bit gaps);
    int g;
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          in_valid = 1'b0;
          in_re    = W'($urandom);
          in_im    = W'($urandom);
          @(posedge clk); #1;
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready beat %0d: in_ready=%b want 1", k, in_ready);
      end
      in_valid = 1'b1;
      in_re    = W'(bin_re[k]);
      in_im    = W'(bin_im[k]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_re    = W'($urandom);
    in_im    = W'($urandom);
  endtask

  task automatic wait_first_output();
    int lat;
    bit flag_bad;
    lat = 0;
    flag_bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) flag_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (flag_bad) begin
      errors++;
      $display("FAIL compute_flags: in_ready/busy wrong during compute (in_ready must be 0, busy 1)");
    end
    checks++;
    if (lat != 12) begin
      errors++;
      $display("FAIL latency: out_valid after %0d edges, want 12", lat);
    end
  endtask

  task automatic unload_frame(input bit rnd, input string tag);
    int n, guard;
    logic signed [W-1:0] er, ei;
    logic el, rdy, vld;
    n = 0;
    guard = 0;
    while (n < 8 && guard < 300) begin
      vld = out_valid;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s unload_flags n=%0d: out_valid=%b in_ready=%b busy=%b want 1 0 1",
                 tag, n, out_valid, in_ready, busy);
        break;
      end
      er = W'(exp_re[n]);
      ei = W'(exp_im[n]);
      el = (n == 7);
      checks++;
      if (out_re !== er || out_im !== ei || out_last !== el) begin
        errors++;
        $display("FAIL %s sample %0d: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                 tag, n, out_re, out_im, out_last, er, ei, el);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      @(posedge clk); #1;
      guard++;
      if (vld === 1'b1 && rdy) n++;
    end
    out_ready = 1'b0;
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL %s unload_count: transferred %0d want 8", tag, n);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s post_unload: out_valid=%b in_ready=%b busy=%b want 0 1 0",
               tag, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      in_valid  = 1'($urandom);
      in_re     = W'($urandom);
      in_im     = W'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b out_last=%b want 1 0 0 0",
               in_ready, out_valid, busy, out_last);
    end
    checks++;
    if (out_re !== 12'sd0 || out_im !== 12'sd0) begin
      errors++;
      $display("FAIL reset_data: re=%0d im=%0d want 0 0", out_re, out_im);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_impulse_bin0();
    set_impulse(0, 80);
    for (int n = 0; n < 8; n++) begin
      exp_re[n] = 10;
      exp_im[n] = 0;
    end
    out_ready = 1'b1;
    drive_frame(1'b0);
    wait_first_output();
    unload_frame(1'b0, "bin0");
  endtask

  task automatic set_bin1_expect();
    exp_re = '{10, 7, 0, -7, -10, -7, 0, 7};
    exp_im = '{0, 7, 10, 7, 0, -7, -10, -7};
  endtask

  task automatic test_impulse_bin1();
    set_impulse(1, 80);
    set_bin1_expect();
    drive_frame(1'b0);
    wait_first_output();
    unload_frame(1'b0, "bin1");
  endtask

  task automatic test_neg_dc();
    set_impulse(0, -2048);
    for (int n = 0; n < 8; n++) begin
      exp_re[n] = -256;
      exp_im[n] = 0;
    end
    drive_frame(1'b0);
    wait_first_output();
    unload_frame(1'b0, "neg_dc");
  endtask

  task automatic test_backpressure();
    set_impulse(1, 80);
    set_bin1_expect();
    drive_frame(1'b1);
    wait_first_output();
    unload_frame(1'b1, "backpressure");
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_impulse(1, 80);
    drive_frame(1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_flags: in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    seen = 1'b0;
    repeat (30) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_quiet: out_valid_seen=%b in_ready=%b want 0 1", seen, in_ready);
    end
    set_impulse(0, 80);
    for (int n = 0; n < 8; n++) begin
      exp_re[n] = 10;
      exp_im[n] = 0;
    end
    drive_frame(1'b0);
    wait_first_output();
    unload_frame(1'b0, "after_reset");
  endtask

  task automatic test_back_to_back_random();
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 8; k++) begin
        bin_re[k] = int'($urandom_range(0, 4095)) - 2048;
        bin_im[k] = int'($urandom_range(0, 4095)) - 2048;
      end
      model_frame();
      drive_frame(f[0]);
      wait_first_output();
      unload_frame(f[0], "random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    test_reset();
    test_impulse_bin0();
    test_impulse_bin1();
    test_neg_dc();
    test_backpressure();
    test_reset_mid();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
